// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub_pkg
// Purpose  : Shared types and helpers for the serial_sub digit-serial
//            subtractor: FSM state encoding and the STEPS calculation.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Number of RUN cycles needed to consume a WIDTH-bit operand DIGIT bits
  // at a time.
  function automatic int calc_steps(input int width, input int digit);
    return width / digit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_sub_fsub_cell.sv
`default_nettype none
// ============================================================================
// Module   : fsub_cell
// Purpose  : One-bit combinational full subtractor, x - y - bi.
// Ports    : x    in  1  minuend bit
//            y    in  1  subtrahend bit
//            bi   in  1  borrow-in
//            diff out 1  difference bit
//            bo   out 1  borrow-out
// Revision : 1.0 - initial release
// ============================================================================
module fsub_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic diff,
  output logic bo
);

  assign diff = x ^ y ^ bi;
  // Borrow when y beats x outright, or when x==y and a borrow arrives.
  assign bo   = (~x & y) | (~(x ^ y) & bi);

endmodule
`default_nettype wire

// File: rtl/serial_sub.sv
`default_nettype none
// ============================================================================
// Module   : serial_sub
// Purpose  : Digit-serial subtractor computing d = a - b - bin over WIDTH
//            bits, DIGIT bits per clock, LSB digit first, through a chain of
//            DIGIT fsub_cell instances and a registered borrow. Operands in
//            and results out use valid/ready handshakes.
// Ports    : clk       in  1      clock, rising edge
//            rst       in  1      synchronous active-high reset
//            in_valid  in  1      operands present
//            in_ready  out 1      idle, able to accept operands
//            a         in  WIDTH  minuend
//            b         in  WIDTH  subtrahend
//            bin       in  1      borrow-in
//            out_valid out 1      result held
//            out_ready in  1      consumer accepts result
//            d         out WIDTH  difference
//            bout      out 1      borrow-out
//            ovf       out 1      signed overflow (SERIAL_SUB_OVF_EN only)
// Config   : define SERIAL_SUB_OVF_EN to add the ovf port and sign capture.
// Revision : 1.0 - initial release
// ============================================================================
module serial_sub
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STEPS = calc_steps(WIDTH, DIGIT);
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  generate
    if ((WIDTH < 2) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
      $error("serial_sub: WIDTH must be >= 2 and DIGIT must divide WIDTH");
    end
  endgenerate

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic             borrow;
  logic [CNT_W-1:0] cnt;

  logic [DIGIT:0]   chain_b;
  logic [DIGIT-1:0] chain_diff;
  logic             chain_bo;
  logic [WIDTH-1:0] res_next;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Ripple chain over the low DIGIT bits of the operand shift registers.
  assign chain_b[0] = borrow;
  generate
    for (genvar k = 0; k < DIGIT; k++) begin : g_cell
      fsub_cell u_cell (
        .x    (a_sh[k]),
        .y    (b_sh[k]),
        .bi   (chain_b[k]),
        .diff (chain_diff[k]),
        .bo   (chain_b[k+1])
      );
    end
  endgenerate
  assign chain_bo = chain_b[DIGIT];

  // New digits enter at the top so that after STEPS shifts the first
  // (least significant) digit has reached bit 0.
  generate
    if (DIGIT == WIDTH) begin : g_res_full
      assign res_next = chain_diff;
    end else begin : g_res_shift
      assign res_next = {chain_diff, d[WIDTH-1:DIGIT]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      d      <= '0;
      bout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh   <= a;
            b_sh   <= b;
            borrow <= bin;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          d      <= res_next;
          borrow <= chain_bo;
          if (cnt == LAST_STEP) begin
            bout  <= chain_bo;
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  // Operand sign bits are kept aside because the shift registers lose them.
  logic a_sign;
  logic b_sign;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sign <= 1'b0;
      b_sign <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if ((state == IDLE) && in_valid) begin
        a_sign <= a[WIDTH-1];
        b_sign <= b[WIDTH-1];
      end
      if ((state == RUN) && (cnt == LAST_STEP)) begin
        ovf <= (a_sign ^ b_sign) & (res_next[WIDTH-1] ^ a_sign);
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_sub.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_sub
// Purpose  : Self-checking bench for serial_sub with a WIDTH=8/DIGIT=1 and a
//            WIDTH=16/DIGIT=4 instance; a scoreboard queue per instance holds
//            expected results pushed at acceptance and popped at out_valid.
// Config   : honours SERIAL_SUB_OVF_EN for the ovf port.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_sub;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        iv8, ir8, ov8, or8, bin8, bo8;
  logic [7:0]  a8, b8, d8;
  logic        iv16, ir16, ov16, or16, bin16, bo16;
  logic [15:0] a16, b16, d16;
`ifdef SERIAL_SUB_OVF_EN
  logic        ovf8, ovf16;
`endif

  serial_sub #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .bin(bin8), .out_valid(ov8), .out_ready(or8), .d(d8), .bout(bo8)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_sub #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .bin(bin16), .out_valid(ov16), .out_ready(or16), .d(d16), .bout(bo16)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf16)
`endif
  );

  typedef struct {
    logic [15:0] d;
    logic        bout;
    logic        ovf;
  } exp_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       bin;
    logic [7:0] d;
    logic       bout;
    logic       ovf;
  } vec8_t;

  exp_t q8[$];
  exp_t q16[$];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 8-bit operation; hold = cycles to keep out_ready low in DONE while
  // stray in_valid pulses are applied.
  task automatic do_op8(input logic [7:0] a, input logic [7:0] b, input logic bi,
                        input logic [7:0] ed, input logic eb, input logic eo,
                        input int hold, input string nm);
    int   lat;
    exp_t e;
    lat = 0;
    while (!ir8 && lat < 50) begin tick(); lat++; end
    check({nm, " in_ready"}, 32'(ir8), 32'd1);
    a8 = a; b8 = b; bin8 = bi; iv8 = 1'b1;
    e.d = 16'(ed); e.bout = eb; e.ovf = eo;
    q8.push_back(e);
    tick();
    iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); bin8 = 1'($urandom);
    lat = 0;
    while (!ov8 && lat < 50) begin tick(); lat++; end
    check({nm, " latency"}, 32'(lat), 32'd8);
    if (ov8) begin
      e = q8.pop_front();
      check({nm, " d"}, 32'(d8), 32'(e.d));
      check({nm, " bout"}, 32'(bo8), 32'(e.bout));
`ifdef SERIAL_SUB_OVF_EN
      check({nm, " ovf"}, 32'(ovf8), 32'(e.ovf));
`endif
      for (int i = 0; i < hold; i++) begin
        iv8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
        tick();
        check({nm, " hold valid"}, 32'(ov8), 32'd1);
        check({nm, " hold d"}, 32'(d8), 32'(e.d));
        check({nm, " hold bout"}, 32'(bo8), 32'(e.bout));
        check({nm, " hold in_ready"}, 32'(ir8), 32'd0);
      end
      iv8 = 1'b0;
      or8 = 1'b1;
      tick();
      or8 = 1'b0;
      check({nm, " release valid"}, 32'(ov8), 32'd0);
      check({nm, " release in_ready"}, 32'(ir8), 32'd1);
      if (hold > 0) begin
        for (int i = 0; i < 10; i++) tick();
        check({nm, " no queued op"}, 32'(ov8), 32'd0);
      end
    end else begin
      void'(q8.pop_front());
      check({nm, " out_valid timeout"}, 32'(ov8), 32'd1);
    end
  endtask

  task automatic do_op16(input logic [15:0] a, input logic [15:0] b, input logic bi,
                         input string nm);
    int          lat;
    exp_t        e;
    logic [16:0] full;
    full   = {1'b0, a} - {1'b0, b} - 17'(bi);
    e.d    = full[15:0];
    e.bout = full[16];
    e.ovf  = (a[15] ^ b[15]) & (full[15] ^ a[15]);
    lat = 0;
    while (!ir16 && lat < 50) begin tick(); lat++; end
    check({nm, " in_ready"}, 32'(ir16), 32'd1);
    a16 = a; b16 = b; bin16 = bi; iv16 = 1'b1;
    q16.push_back(e);
    tick();
    iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    lat = 0;
    while (!ov16 && lat < 50) begin tick(); lat++; end
    check({nm, " latency"}, 32'(lat), 32'd4);
    e = q16.pop_front();
    if (ov16) begin
      check({nm, " d"}, 32'(d16), 32'(e.d));
      check({nm, " bout"}, 32'(bo16), 32'(e.bout));
`ifdef SERIAL_SUB_OVF_EN
      check({nm, " ovf"}, 32'(ovf16), 32'(e.ovf));
`endif
      or16 = 1'b1;
      tick();
      or16 = 1'b0;
      check({nm, " release in_ready"}, 32'(ir16), 32'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec8_t tbl[8];
    tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    tbl[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0};
    tbl[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0};
    tbl[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    tbl[4] = '{8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0};
    tbl[5] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1};
    tbl[6] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[7] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};

    // Reset with handshakes asserted: they must be ignored.
    rst = 1'b1;
    iv8 = 1'b1; a8 = 8'h5A; b8 = 8'h11; bin8 = 1'b0; or8 = 1'b1;
    iv16 = 1'b1; a16 = 16'h1111; b16 = 16'h2222; bin16 = 1'b0; or16 = 1'b1;
    repeat (3) tick();
    check("reset in_ready", 32'(ir8), 32'd1);
    rst = 1'b0; iv8 = 1'b0; or8 = 1'b0; iv16 = 1'b0; or16 = 1'b0;
    tick();
    check("reset out_valid", 32'(ov8), 32'd0);
    check("reset d", 32'(d8), 32'd0);
    check("reset bout", 32'(bo8), 32'd0);
    check("reset d16", 32'(d16), 32'd0);
    check("reset in_ready16", 32'(ir16), 32'd1);
`ifdef SERIAL_SUB_OVF_EN
    check("reset ovf", 32'(ovf8), 32'd0);
`endif

    for (int i = 0; i < 8; i++)
      do_op8(tbl[i].a, tbl[i].b, tbl[i].bin, tbl[i].d, tbl[i].bout, tbl[i].ovf,
             0, $sformatf("vec8[%0d]", i));

    // Backpressure: 5 cycles of out_ready low with stray in_valid pulses.
    do_op8(8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0, 5, "backpressure");

    // Reset during the 4th RUN cycle aborts the operation.
    a8 = 8'h55; b8 = 8'h22; bin8 = 1'b0; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort in_ready", 32'(ir8), 32'd1);
    check("abort out_valid", 32'(ov8), 32'd0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
        tick();
        if (ov8) seen++;
      end
      check("abort no result", 32'(seen), 32'd0);
    end
    do_op8(8'h0A, 8'h0A, 1'b0, 8'h00, 1'b0, 1'b0, 0, "after abort");

    // 16-bit, 4-bit digits.
    do_op16(16'h1234, 16'h4321, 1'b0, "w16 spec");
    check("w16 spec d const", 32'(d16), 32'h0000CF13);
    do_op16(16'h8000, 16'h0001, 1'b0, "w16 minneg");
    do_op16(16'hFFFF, 16'hFFFF, 1'b1, "w16 all ones");
    for (int i = 0; i < 1000; i++)
      do_op16(16'($urandom), 16'($urandom), 1'($urandom), "w16 random");

    check("scoreboard8 empty", 32'(q8.size()), 32'd0);
    check("scoreboard16 empty", 32'(q16.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_sub.md
# serial_sub

Parametrised multi-cycle subtractor computing D = A − B − Bin over WIDTH bits, DIGIT bits per clock, LSB digit first, through a chain of DIGIT one-bit full-subtractor cells and a registered borrow. It is the sequential, width-generic successor to the team's one-bit full-subtractor cell. It is for datapaths that trade latency for area. Operands enter and results leave through valid/ready handshakes.

## Interface

Parameters:
- WIDTH, 8: operand and result width. Must be ≥ 2.
- DIGIT, 1: bits processed per cycle. Must be ≥ 1 and divide WIDTH. STEPS = WIDTH/DIGIT.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block idle and able to accept.
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- bin  in  1  borrow-in.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts result.
- d  out  WIDTH  difference.
- bout  out  1  borrow-out.
- ovf  out  1  signed overflow. Present only with SERIAL_SUB_OVF_EN.

## Operation

- States (FSM):
  - IDLE: in_ready=1.
  - RUN: processes one digit per cycle.
  - DONE: out_valid=1.
- IDLE → RUN on in_valid & in_ready:
  - capture a and b into shift registers;
  - borrow register ← bin;
  - step counter ← 0.
- RUN, each cycle:
  - the low DIGIT bits of the a/b shift registers go through the cell chain; cell k borrow-in = cell k−1 borrow-out; cell 0 borrow-in = borrow register;
  - the chain's difference bits shift into the top of the result register; the operand registers shift right by DIGIT;
  - borrow register ← last cell's borrow-out;
  - counter increments.
  - When counter = STEPS−1, go to DONE at that edge.
- DONE:
  - d = full result; bout = final borrow.
  - Hold d, bout and ovf stable until out_ready; then go to IDLE.
- Arithmetic:
  - d = (a − b − bin) mod 2^WIDTH.
  - bout = 1 iff a < b + bin, unsigned.
- in_valid outside IDLE is ignored; operands are not queued.
- a and b changing after acceptance have no effect.

## Timing

- Reset: state=IDLE, out_valid=0, d=0, bout=0, ovf=0, counter=0. in_ready=1 from the first cycle with rst low.
- While rst is high, all handshakes are ignored.
- Reset mid-RUN or mid-DONE aborts the operation. No out_valid is produced and the result is discarded.
- in_ready and out_valid are decoded from registered state only. There is no combinational path from in_valid or out_ready.
- Latency: acceptance at edge E0 means out_valid=1 after edge E0+STEPS.
- DONE→IDLE on the edge where out_valid & out_ready. in_ready rises in the following cycle.
- Minimum issue interval: STEPS+2 cycles.
- DIGIT=WIDTH gives STEPS=1: a single RUN cycle.
- Counter width: $clog2(STEPS) with a minimum of 1 bit. The counter never wraps within an operation.

## Configuration

- Macro SERIAL_SUB_OVF_EN.
- Defined:
  - ovf port present;
  - ovf = (a[WIDTH−1] ≠ b[WIDTH−1]) & (d[WIDTH−1] ≠ a[WIDTH−1]), using the captured operand sign bits;
  - registered on entry to DONE; reset 0.
- Undefined: port and sign-capture flops absent. All other behaviour is identical.

## Structure

- Package serial_sub_pkg:
  - state typedef: IDLE=2'b00, RUN=2'b01, DONE=2'b10;
  - helper function returning STEPS from WIDTH and DIGIT.
- Sub-module fsub_cell, one-bit combinational:
  - inputs x, y, bi; outputs diff, bo;
  - diff = x^y^bi;
  - bo = (~x&y) | (~(x^y)&bi);
  - instantiated DIGIT times in a generate chain.
- Elaboration check rejects a DIGIT that does not divide WIDTH.

## Test plan

- WIDTH=8, DIGIT=1; a=0x05, b=0x03, bin=0 → d=0x02, bout=0; out_valid exactly 8 edges after acceptance.
- a=0x00, b=0x01, bin=0 → d=0xFF, bout=1. Then a=0x10, b=0x0F, bin=1 → d=0x00, bout=0.
- With SERIAL_SUB_OVF_EN, a=0x80, b=0x01 → d=0x7F, ovf=1, bout=0. a=0x7F, b=0x01 → d=0x7E, ovf=0.
- Backpressure: out_ready low 5 cycles in DONE → d, bout, out_valid stable and in_valid pulses ignored. in_ready rises 1 cycle after out_ready.
- rst pulsed during the 4th RUN cycle → no out_valid, in_ready=1 next cycle. A fresh op a=0x0A, b=0x0A → d=0x00, bout=0.
- WIDTH=16, DIGIT=4; a=0x1234, b=0x4321 → d=0xCF13, bout=1; latency 4. Also an exhaustive-random compare against a − b − bin for 1000 ops.
